instruction_store: RTL and testbench

- Program memory that answers the microprocessor's instruction fetches: it takes instruction_address and returns instruction.
- Contents are loaded at run time through a byte-serial valid/ready port fed by the board-level loader.
- Unused locations are auto-filled with a halt word.
- cpu_hold keeps the processor in reset until a load completes.

---
 rtl/instruction_store_if.sv | 32 +++
 rtl/instruction_store.sv | 160 ++++++++++++++++
 tb/tb_instruction_store.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_store_if.sv
// Loader-side byte stream into the instruction store.
//   load_start  : single-cycle pulse, begins a new program load
//   load_valid  : load_data carries a byte this cycle
//   load_data   : program byte
//   load_last   : marks the final byte of the program (sampled with load_valid)
//   load_ready  : store accepts a byte this cycle
// master = board-level loader, slave = instruction_store.
interface instruction_store_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  load_start;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;

    modport master (
        output load_start,
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_start,
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/instruction_store.sv
// Program memory for the microprocessor. A program is streamed in byte by
// byte through load_bus, the unused tail of the memory is filled with a halt
// word, and only then is the processor released from reset.
//
// Ports:
//   clock               : system clock, shared with the processor
//   reset               : asynchronous, active-high
//   load_bus            : loader byte stream (slave side)
//   instruction_address : fetch address (processor PC)
//   instruction         : registered fetch data, 1-cycle latency
//   cpu_hold            : high = processor held in reset
//   load_count          : bytes accepted in the most recent load (0..256)
//   load_error          : sticky protocol-violation flag
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no valid program; waiting for load_start
// LOAD  | accepting program bytes into mem[wp]
// FILL  | writing FILL_WORD into every location above the program
// RUN   | program complete; serving fetches, processor released
module instruction_store #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = 8'hC3
) (
    input  logic                  clock,
    input  logic                  reset,
    instruction_store_if.slave    load_bus,
    input  logic [ADDR_WIDTH-1:0] instruction_address,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  load_error
);

    localparam int                  DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FILL,
        RUN
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] wp, wp_next;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  error_next;
    logic                  ready;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_en;

    // No reset on the array so it maps onto a plain synchronous RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign load_bus.load_ready = ready;

    always_comb begin
        state_next = state;
        wp_next    = wp;
        count_next = load_count;
        error_next = load_error;
        ready      = 1'b0;
        write_en   = 1'b0;
        write_data = load_bus.load_data;
        read_en    = 1'b0;

        case (state)
            IDLE: begin
                if (load_bus.load_start) begin
                    state_next = LOAD;
                    wp_next    = '0;
                    count_next = '0;
                    error_next = 1'b0;
                end
            end

            LOAD: begin
                ready = 1'b1;
                if (load_bus.load_start) begin
                    error_next = 1'b1;
                end
                if (load_bus.load_valid) begin
                    write_en   = 1'b1;
                    wp_next    = wp + ADDR_ONE;
                    count_next = load_count + COUNT_ONE;
                    // A full-depth program leaves nothing to fill.
                    if (wp == ADDR_LAST) begin
                        state_next = RUN;
                    end else if (load_bus.load_last) begin
                        state_next = FILL;
                    end
                end
            end

            FILL: begin
                write_en   = 1'b1;
                write_data = FILL_WORD;
                wp_next    = wp + ADDR_ONE;
                if (wp == ADDR_LAST) begin
                    state_next = RUN;
                end
                if (load_bus.load_valid || load_bus.load_start) begin
                    error_next = 1'b1;
                end
            end

            RUN: begin
                // load_start outranks a coincident load_valid and is not an error.
                if (load_bus.load_start) begin
                    state_next = LOAD;
                    wp_next    = '0;
                    count_next = '0;
                    error_next = 1'b0;
                end else begin
                    read_en = 1'b1;
                    if (load_bus.load_valid) begin
                        error_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wp          <= '0;
            load_count  <= '0;
            load_error  <= 1'b0;
            instruction <= '0;
            cpu_hold    <= 1'b1;
        end else begin
            state      <= state_next;
            wp         <= wp_next;
            load_count <= count_next;
            load_error <= error_next;
            // Released only on the edge that enters RUN, so the processor
            // never runs against a partly written memory.
            cpu_hold   <= (state_next != RUN);
            instruction <= read_en ? mem[instruction_address] : '0;
        end
    end

    // Write port is used only in LOAD/FILL, read port only in RUN.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[wp] <= write_data;
        end
    end

endmodule

// File: tb/tb_instruction_store.sv
// Directed bench for instruction_store: loads small, gapped and full-depth
// programs, checks fill length, fetch data, error flag and reset behaviour.
module tb_instruction_store;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] instruction_address = '0;
    logic [7:0] instruction;
    logic       cpu_hold;
    logic [8:0] load_count;
    logic       load_error;

    instruction_store_if #(.DATA_WIDTH(8)) load_bus ();

    instruction_store dut (
        .clock               (clock),
        .reset               (reset),
        .load_bus            (load_bus),
        .instruction_address (instruction_address),
        .instruction         (instruction),
        .cpu_hold            (cpu_hold),
        .load_count          (load_count),
        .load_error          (load_error)
    );

    always #5 clock = ~clock;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] prog    [256];
    logic [7:0] exp_mem [256];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load(input logic with_valid);
        load_bus.load_start = 1'b1;
        load_bus.load_valid = with_valid;
        step();
        load_bus.load_start = 1'b0;
        load_bus.load_valid = 1'b0;
    endtask

    task automatic send_bytes(input int n, input logic with_last, input logic gap);
        for (int i = 0; i < n; i++) begin
            load_bus.load_valid = 1'b1;
            load_bus.load_data  = prog[i];
            load_bus.load_last  = with_last && (i == n - 1);
            step();
            load_bus.load_valid = 1'b0;
            load_bus.load_last  = 1'b0;
            if (gap) step();
        end
    endtask

    task automatic wait_run(output int cycles);
        cycles = 0;
        while (cpu_hold && cycles < 400) begin
            step();
            cycles++;
        end
        check("run_timeout", {31'd0, cpu_hold}, 32'd0);
    endtask

    task automatic set_expect(input int n);
        for (int i = 0; i < 256; i++) exp_mem[i] = (i < n) ? prog[i] : 8'hC3;
    endtask

    task automatic fetch(input string tag, input logic [7:0] addr);
        instruction_address = addr;
        step();
        check(tag, {24'd0, instruction}, {24'd0, exp_mem[addr]});
    endtask

    int cyc;

    initial begin
        load_bus.load_start = 1'b0;
        load_bus.load_valid = 1'b0;
        load_bus.load_data  = '0;
        load_bus.load_last  = 1'b0;

        // Reset state
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_hold",  {31'd0, cpu_hold}, 32'd1);
        check("rst_instr", {24'd0, instruction}, 32'd0);
        check("rst_count", {23'd0, load_count}, 32'd0);
        check("rst_error", {31'd0, load_error}, 32'd0);
        check("rst_ready", {31'd0, load_bus.load_ready}, 32'd0);

        // Three-byte program, load_valid held high
        prog[0] = 8'h01; prog[1] = 8'h24; prog[2] = 8'hC3;
        start_load(1'b0);
        check("load_ready", {31'd0, load_bus.load_ready}, 32'd1);
        send_bytes(3, 1'b1, 1'b0);
        check("fill_ready", {31'd0, load_bus.load_ready}, 32'd0);
        wait_run(cyc);
        check("fill_cycles3", cyc, 32'd253);
        check("count3", {23'd0, load_count}, 32'd3);
        check("error3", {31'd0, load_error}, 32'd0);
        set_expect(3);
        fetch("t1_a0", 8'h00);
        instruction_address = 8'h01;
        #1;
        check("t1_latency", {24'd0, instruction}, 32'h01);
        fetch("t1_a1", 8'h01);
        fetch("t1_a2", 8'h02);
        fetch("t1_a3", 8'h03);
        fetch("t1_aff", 8'hFF);
        fetch("t1_a1b", 8'h01);

        // Full-depth load, data = address, no load_last
        for (int i = 0; i < 256; i++) prog[i] = 8'(i);
        start_load(1'b0);
        check("full_count0", {23'd0, load_count}, 32'd0);
        send_bytes(256, 1'b0, 1'b0);
        check("full_hold", {31'd0, cpu_hold}, 32'd0);
        wait_run(cyc);
        check("full_fill_cycles", cyc, 32'd0);
        check("full_count", {23'd0, load_count}, 32'd256);
        set_expect(256);
        fetch("full_aa5", 8'hA5);
        fetch("full_a00", 8'h00);
        fetch("full_aff", 8'hFF);

        // Gapped load_valid, two-byte program
        prog[0] = 8'h11; prog[1] = 8'h22;
        start_load(1'b0);
        send_bytes(2, 1'b1, 1'b1);
        wait_run(cyc);
        check("gap_count", {23'd0, load_count}, 32'd2);
        check("gap_fill_cycles", cyc, 32'd253);
        set_expect(2);
        for (int a = 0; a < 256; a++) fetch("gap_mem", 8'(a));

        // Protocol errors
        prog[0] = 8'h55; prog[1] = 8'h66;
        start_load(1'b0);
        send_bytes(1, 1'b0, 1'b0);
        load_bus.load_start = 1'b1;
        step();
        load_bus.load_start = 1'b0;
        check("err_load_start", {31'd0, load_error}, 32'd1);
        prog[0] = 8'h66;
        send_bytes(1, 1'b1, 1'b0);
        wait_run(cyc);
        check("err_sticky", {31'd0, load_error}, 32'd1);
        check("err_count", {23'd0, load_count}, 32'd2);
        load_bus.load_valid = 1'b1;
        load_bus.load_data  = 8'hEE;
        step();
        load_bus.load_valid = 1'b0;
        check("err_run_valid", {31'd0, load_error}, 32'd1);
        prog[0] = 8'h55; prog[1] = 8'h66;
        set_expect(2);
        fetch("err_a0", 8'h00);
        fetch("err_a1", 8'h01);
        fetch("err_a2", 8'h02);
        start_load(1'b0);
        check("err_cleared", {31'd0, load_error}, 32'd0);
        prog[0] = 8'h77;
        send_bytes(1, 1'b1, 1'b0);
        wait_run(cyc);
        check("err_clean_load", {31'd0, load_error}, 32'd0);
        load_bus.load_valid = 1'b1;
        step();
        load_bus.load_valid = 1'b0;
        check("err_run_only", {31'd0, load_error}, 32'd1);
        set_expect(1);
        fetch("err_a0b", 8'h00);

        // Reset in the middle of a load
        for (int i = 0; i < 5; i++) prog[i] = 8'h90 + 8'(i);
        start_load(1'b0);
        send_bytes(5, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        check("mid_rst_hold",  {31'd0, cpu_hold}, 32'd1);
        check("mid_rst_instr", {24'd0, instruction}, 32'd0);
        check("mid_rst_count", {23'd0, load_count}, 32'd0);
        check("mid_rst_ready", {31'd0, load_bus.load_ready}, 32'd0);
        reset = 1'b0;
        step();
        prog[0] = 8'h40;
        start_load(1'b0);
        send_bytes(1, 1'b1, 1'b0);
        wait_run(cyc);
        check("rl_fill_cycles", cyc, 32'd255);
        check("rl_count", {23'd0, load_count}, 32'd1);
        set_expect(1);
        fetch("rl_a0", 8'h00);
        fetch("rl_a1", 8'h01);
        fetch("rl_a80", 8'h80);
        fetch("rl_aff", 8'hFF);

        // Reload while running; coincident load_valid must not count as error
        fetch("run_a0", 8'h00);
        start_load(1'b1);
        check("reload_hold",  {31'd0, cpu_hold}, 32'd1);
        check("reload_instr", {24'd0, instruction}, 32'd0);
        check("reload_error", {31'd0, load_error}, 32'd0);
        check("reload_count", {23'd0, load_count}, 32'd0);
        prog[0] = 8'h7E;
        send_bytes(1, 1'b1, 1'b0);
        wait_run(cyc);
        set_expect(1);
        fetch("reload_a0", 8'h00);
        fetch("reload_a1", 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
